fifo_sync_core: RTL and testbench

//  Single-clock FIFO buffer: stores BITS-wide words, up to SIZE entries, first-in first-out.
//  It is the storage and flag core used behind the async_fifo interface, with both ports on one clock.
//  It provides full/empty flow control, almost-full/almost-empty thresholds and a fill-level count.

---
 rtl/fifo_sync_core.sv | 75 +++++++
 tb/tb_fifo_sync_core.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_core.sv
// Single-clock FIFO core: BITS-wide words, SIZE entries, registered flags, level and read data.
// Pointers carry one extra wrap bit so full and empty are told apart without a separate counter.
module fifo_sync_core #(
    parameter int unsigned BITS      = 32,
    parameter int unsigned SIZE      = 16,
    parameter int unsigned AFULL_TH  = SIZE - 2,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p_write_en,
    input  logic [BITS-1:0]         p_write_data,
    output logic                    p_write_full,
    output logic                    p_write_almost_full,
    input  logic                    p_read_en,
    output logic [BITS-1:0]         p_read_data,
    output logic                    p_read_empty,
    output logic                    p_read_almost_empty,
    output logic [$clog2(SIZE):0]   p_level
);

    localparam int unsigned ADDR = $clog2(SIZE);
    localparam int unsigned PW   = ADDR + 1;

    logic [BITS-1:0] mem [SIZE];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr_c;
    logic [PW-1:0]   rptr_c;
    logic [PW-1:0]   level_c;
    logic            wr_acc_c;
    logic            rd_acc_c;

    // Acceptance uses the registered flags; next pointers and level feed the flag registers.
    always_comb begin
        wr_acc_c = p_write_en && !p_write_full;
        rd_acc_c = p_read_en && !p_read_empty;
        wptr_c   = wptr + PW'(wr_acc_c);
        rptr_c   = rptr + PW'(rd_acc_c);
        level_c  = wptr_c - rptr_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr                <= '0;
            rptr                <= '0;
            p_level             <= '0;
            p_read_empty        <= 1'b1;
            p_write_full        <= 1'b0;
            p_write_almost_full <= 1'b0;
            p_read_almost_empty <= 1'b1;
            p_read_data         <= '0;
        end else begin
            wptr                <= wptr_c;
            rptr                <= rptr_c;
            p_level             <= level_c;
            p_read_empty        <= (wptr_c == rptr_c);
            p_write_full        <= (wptr_c[ADDR-1:0] == rptr_c[ADDR-1:0]) &&
                                   (wptr_c[ADDR] != rptr_c[ADDR]);
            p_write_almost_full <= (level_c >= PW'(AFULL_TH));
            p_read_almost_empty <= (level_c <= PW'(AEMPTY_TH));
            if (rd_acc_c) begin
                p_read_data <= mem[rptr[ADDR-1:0]];
            end
        end
    end

    // Storage is never cleared; a write during reset is dropped like any other request.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) begin
            mem[wptr[ADDR-1:0]] <= p_write_data;
        end
    end

endmodule

// File: tb/tb_fifo_sync_core.sv
// Bench for fifo_sync_core: queue-based reference model checked every cycle, plus directed
// boundary scenarios with literal expectations and a randomized stress phase.
module tb_fifo_sync_core;

    localparam int unsigned BITS = 32;
    localparam int unsigned SIZE = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic [BITS-1:0] wd;
    logic            re;
    logic            full, afull, empty, aempty;
    logic [BITS-1:0] rdata;
    logic [4:0]      level;

    int vectors     = 0;
    int miscompares = 0;

    fifo_sync_core #(.BITS(BITS), .SIZE(SIZE)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .p_write_en          (we),
        .p_write_data        (wd),
        .p_write_full        (full),
        .p_write_almost_full (afull),
        .p_read_en           (re),
        .p_read_data         (rdata),
        .p_read_empty        (empty),
        .p_read_almost_empty (aempty),
        .p_level             (level)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of stored words and the last word handed out.
    logic [BITS-1:0] q[$];
    logic [BITS-1:0] m_rdata;
    bit              chk_on = 1'b0;

    always @(posedge clk) begin
        int sz;
        sz = q.size();
        if (rst) begin
            q.delete();
            m_rdata = '0;
            chk_on  = 1'b1;
        end else if (chk_on) begin
            if (re && sz != 0) m_rdata = q.pop_front();
            if (we && sz != int'(SIZE)) q.push_back(wd);
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            int sz;
            sz = q.size();
            vectors++;
            if (int'(level) != sz) begin
                miscompares++;
                $display("FAIL level t=%0t got %0d exp %0d", $time, level, sz);
            end
            if (empty !== (sz == 0)) begin
                miscompares++;
                $display("FAIL empty t=%0t got %b exp %b", $time, empty, sz == 0);
            end
            if (full !== (sz == int'(SIZE))) begin
                miscompares++;
                $display("FAIL full t=%0t got %b exp %b", $time, full, sz == int'(SIZE));
            end
            if (afull !== (sz >= int'(SIZE) - 2)) begin
                miscompares++;
                $display("FAIL afull t=%0t got %b exp %b", $time, afull, sz >= int'(SIZE) - 2);
            end
            if (aempty !== (sz <= 2)) begin
                miscompares++;
                $display("FAIL aempty t=%0t got %b exp %b", $time, aempty, sz <= 2);
            end
            if (rdata !== m_rdata) begin
                miscompares++;
                $display("FAIL rdata t=%0t got %h exp %h", $time, rdata, m_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [BITS-1:0] d, input logic r, input logic s);
        we  = w;
        wd  = d;
        re  = r;
        rst = s;
        tick();
    endtask

    task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) drive(1'b1, BITS'(i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        we = 1'b0; wd = '0; re = 1'b0; rst = 1'b1;

        // 1: reset with random requests
        for (int i = 0; i < 3; i++) drive(1'($urandom), BITS'($urandom), 1'($urandom), 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_aempty", 32'(aempty), 32'd1);

        // 2/3: smoke fill, overflow, drain, underflow
        fill16();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_afull", 32'(afull), 32'd1);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("smoke_data", rdata, 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("udf_rdata", rdata, 32'd15);
        chk("udf_level", 32'(level), 32'd0);

        // 4: interleaved stream across many pointer wraps
        for (int i = 0; i < 1000; i++) drive(!full, BITS'(i), !empty, 1'b0);
        chk("stream_level", 32'(level), 32'd1);
        chk("stream_last", rdata, 32'd998);

        // 5: simultaneous requests at full and at empty
        drive(1'b1, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        fill16();
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        chk("sim_full_level", 32'(level), 32'd15);
        chk("sim_full_flag", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) drive(1'b0, '0, 1'b1, 1'b0);
        chk("sim_drained", 32'(empty), 32'd1);
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        chk("sim_empty_level", 32'(level), 32'd1);
        chk("sim_empty_flag", 32'(empty), 32'd0);

        // 6: reset mid-stream discards stored data
        for (int i = 0; i < 10; i++) drive(1'b1, BITS'(32'h100 + i), 1'b0, 1'b0);
        drive(1'b1, 32'hBAD, 1'b1, 1'b1);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_level", 32'(level), 32'd0);
        drive(1'b1, 32'hA5, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("mid_rst_data", rdata, 32'hA5);

        // Randomized stress with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) < 55), BITS'($urandom), ($urandom_range(99) < 50),
                  ($urandom_range(999) < 5));
        end
        drive(1'b0, '0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
